// File: rtl/rop3_mode_recover.sv
// ----------------------------------------------------------------------------
// rop3_mode_recover
//
// Purpose:
//   Inverse of the ROP3 engine. It watches (P, S, D, Result) sample vectors
//   and rebuilds the 8-bit Mode truth table that produced them. Minterm index
//   is {P, S, D} per bit lane, and Result bit = Mode[idx]. The block runs
//   beside the rop3 datapath as a self-check monitor, and it also serves as a
//   reference checker in block-level benches.
//
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   clear      : synchronous restart of recovery (priority over in_valid)
//   in_valid   : sample strobe; P/S/D/Result sampled when high
//   P, S, D    : N-bit operands of the sample
//   Result     : N-bit observed ROP3 output of the sample
//   mode_out   : recovered truth-table bits (unknown bits read 0)
//   known_mask : bit k set once minterm k has been observed
//   done       : all eight minterms known, no conflict seen
//   conflict   : sticky; an inconsistent observation was seen
//   sample_cnt : accepted samples since reset/clear, saturating
// ----------------------------------------------------------------------------
module rop3_mode_recover #(
   parameter int unsigned N     = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [N-1:0]     P,
   input  logic [N-1:0]     S,
   input  logic [N-1:0]     D,
   input  logic [N-1:0]     Result,
   output logic [7:0]       mode_out,
   output logic [7:0]       known_mask,
   output logic             done,
   output logic             conflict,
   output logic [CNT_W-1:0] sample_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2,
      ST_ERR     = 2'd3
   } state_t;

   state_t           r_state;
   logic [7:0]       r_mode;
   logic [7:0]       r_known;
   logic             r_done;
   logic             r_conflict;
   logic [CNT_W-1:0] r_cnt;

   // Per-minterm summary of the current sample: which minterms appear, and
   // whether any lane hitting them carried a 1 and/or a 0.
   logic [7:0] w_hit;
   logic [7:0] w_one;
   logic [7:0] w_zero;
   logic [7:0] w_intra;
   logic [7:0] w_inter;
   logic       w_any_conflict;
   logic [7:0] w_known_nxt;
   logic [7:0] w_mode_nxt;

   always_comb begin
      logic [2:0] w_idx;
      w_hit  = '0;
      w_one  = '0;
      w_zero = '0;
      w_idx  = '0;
      for (int unsigned i = 0; i < N; i++) begin
         w_idx = {P[i], S[i], D[i]};
         w_hit[w_idx] = 1'b1;
         if (Result[i]) begin
            w_one[w_idx] = 1'b1;
         end else begin
            w_zero[w_idx] = 1'b1;
         end
      end
   end

   always_comb begin
      // new_val[k] is w_one[k]; it only matters where w_hit[k] is set.
      w_intra        = w_one & w_zero;
      w_inter        = r_known & w_hit & (w_one ^ r_mode);
      w_any_conflict = |(w_intra | w_inter);
      w_known_nxt    = r_known | w_hit;
      // Unknown bits of r_mode are always 0, so OR-ing in the newly hit
      // values leaves the already-known bits untouched.
      w_mode_nxt     = r_mode | (w_one & w_hit & ~r_known);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_mode     <= '0;
         r_known    <= '0;
         r_done     <= 1'b0;
         r_conflict <= 1'b0;
         r_cnt      <= '0;
      end else if (clear) begin
         r_state    <= ST_IDLE;
         r_mode     <= '0;
         r_known    <= '0;
         r_done     <= 1'b0;
         r_conflict <= 1'b0;
         r_cnt      <= '0;
      end else if (in_valid && (r_state != ST_ERR)) begin
         r_known <= w_known_nxt;
         r_mode  <= w_mode_nxt;
         if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_any_conflict) begin
            r_state    <= ST_ERR;
            r_conflict <= 1'b1;
            r_done     <= 1'b0;
         end else if (&w_known_nxt) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
         end else begin
            r_state <= ST_COLLECT;
            r_done  <= 1'b0;
         end
      end
   end

   assign mode_out   = r_mode;
   assign known_mask = r_known;
   assign done       = r_done;
   assign conflict   = r_conflict;
   assign sample_cnt = r_cnt;

endmodule

// File: tb/tb_rop3_mode_recover.sv
// ----------------------------------------------------------------------------
// tb_rop3_mode_recover
//
// Purpose:
//   Directed, table-driven bench for rop3_mode_recover. Each table row is one
//   clock cycle of stimulus plus the outputs expected after that edge. The
//   asynchronous reset case is written out by hand after the table.
// ----------------------------------------------------------------------------
module tb_rop3_mode_recover;

   localparam int unsigned N     = 8;
   localparam int unsigned CNT_W = 16;

   logic             clk;
   logic             rst_n;
   logic             clear;
   logic             in_valid;
   logic [N-1:0]     P;
   logic [N-1:0]     S;
   logic [N-1:0]     D;
   logic [N-1:0]     Result;
   logic [7:0]       mode_out;
   logic [7:0]       known_mask;
   logic             done;
   logic             conflict;
   logic [CNT_W-1:0] sample_cnt;

   int checks;
   int errors;

   rop3_mode_recover #(.N(N), .CNT_W(CNT_W)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .in_valid   (in_valid),
      .P          (P),
      .S          (S),
      .D          (D),
      .Result     (Result),
      .mode_out   (mode_out),
      .known_mask (known_mask),
      .done       (done),
      .conflict   (conflict),
      .sample_cnt (sample_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        clr;
      logic        vld;
      logic [7:0]  p;
      logic [7:0]  s;
      logic [7:0]  d;
      logic [7:0]  r;
      logic [7:0]  e_mode;
      logic [7:0]  e_known;
      logic        e_done;
      logic        e_conf;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(string name, logic clr, logic vld,
                               logic [7:0] p, logic [7:0] s, logic [7:0] d,
                               logic [7:0] r, logic [7:0] e_mode,
                               logic [7:0] e_known, logic e_done,
                               logic e_conf, logic [15:0] e_cnt);
      vec_t v;
      v.name = name; v.clr = clr; v.vld = vld;
      v.p = p; v.s = s; v.d = d; v.r = r;
      v.e_mode = e_mode; v.e_known = e_known;
      v.e_done = e_done; v.e_conf = e_conf; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_all(string tag, logic [7:0] e_mode, logic [7:0] e_known,
                          logic e_done, logic e_conf, logic [15:0] e_cnt);
      chk({tag, ".mode_out"},   32'(mode_out),   32'(e_mode));
      chk({tag, ".known_mask"}, 32'(known_mask), 32'(e_known));
      chk({tag, ".done"},       32'(done),       32'(e_done));
      chk({tag, ".conflict"},   32'(conflict),   32'(e_conf));
      chk({tag, ".sample_cnt"}, 32'(sample_cnt), 32'(e_cnt));
   endtask

   task automatic drive(logic clr, logic vld, logic [7:0] p, logic [7:0] s,
                        logic [7:0] d, logic [7:0] r);
      @(negedge clk);
      clear = clr; in_valid = vld; P = p; S = s; D = d; Result = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
      P = '0; S = '0; D = '0; Result = '0;

      //              name           clr vld  P      S      D      Res    mode   known  dn cf cnt
      vecs.push_back(mk("clr0",      1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0));
      vecs.push_back(mk("full_S",    0, 1, 8'hF0, 8'hCC, 8'hAA, 8'hCC, 8'hCC, 8'hFF, 1, 0, 1));
      vecs.push_back(mk("clr1",      1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0));
      vecs.push_back(mk("full_PxD",  0, 1, 8'hF0, 8'hCC, 8'hAA, 8'h5A, 8'h5A, 8'hFF, 1, 0, 1));
      vecs.push_back(mk("clr2",      1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0));
      vecs.push_back(mk("inc1",      0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 0, 0, 1));
      vecs.push_back(mk("idle_hold", 0, 0, 8'hFF, 8'h0F, 8'h33, 8'h55, 8'h00, 8'h01, 0, 0, 1));
      vecs.push_back(mk("inc2",      0, 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h80, 8'h81, 0, 0, 2));
      vecs.push_back(mk("inc3",      0, 1, 8'hF0, 8'hCC, 8'hAA, 8'hEE, 8'hEE, 8'hFF, 1, 0, 3));
      vecs.push_back(mk("done_cons", 0, 1, 8'hF0, 8'hCC, 8'hAA, 8'hEE, 8'hEE, 8'hFF, 1, 0, 4));
      vecs.push_back(mk("clr3",      1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0));
      vecs.push_back(mk("intra",     0, 1, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 0, 1, 1));
      vecs.push_back(mk("err_frz",   0, 1, 8'hF0, 8'hCC, 8'hAA, 8'hCC, 8'h01, 8'h01, 0, 1, 1));
      vecs.push_back(mk("clr4",      1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0));
      vecs.push_back(mk("full_S2",   0, 1, 8'hF0, 8'hCC, 8'hAA, 8'hCC, 8'hCC, 8'hFF, 1, 0, 1));
      vecs.push_back(mk("inter",     0, 1, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hCC, 8'hFF, 0, 1, 2));
      vecs.push_back(mk("clr_vld",   1, 1, 8'hF0, 8'hCC, 8'hAA, 8'hCC, 8'h00, 8'h00, 0, 0, 0));
      vecs.push_back(mk("post_clr",  0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0));

      // Reset state
      #12;
      chk_all("reset", 8'h00, 8'h00, 1'b0, 1'b0, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].clr, vecs[i].vld, vecs[i].p, vecs[i].s, vecs[i].d, vecs[i].r);
         chk_all(vecs[i].name, vecs[i].e_mode, vecs[i].e_known,
                 vecs[i].e_done, vecs[i].e_conf, vecs[i].e_cnt);
      end

      // Asynchronous reset mid-collection
      drive(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
      drive(1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      chk_all("pre_arst", 8'h80, 8'h81, 1'b0, 1'b0, 16'd2);
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("arst_now", 8'h00, 8'h00, 1'b0, 1'b0, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 8'hF0, 8'hCC, 8'hAA, 8'hAA);
      chk_all("post_arst", 8'hAA, 8'hFF, 1'b1, 1'b0, 16'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
